// File: rtl/gelato_ibuffer.sv
// Per-warp instruction buffer between decode and dispatch.
// Each warp owns a circular FIFO of DEPTH decoded instructions, so back-pressure
// and flushes apply to one warp without disturbing the others.
//
// Ports:
//   clk, rst_n        clock; synchronous active-high reset (1 = reset)
//   rdy               global enable; 0 freezes all state
//   in_valid/in_warp/in_inst   push from decode
//   in_ready          FIFO selected by in_warp is not full
//   warp_full         per-warp full flags
//   head_valid        per-warp non-empty flags
//   pop_valid/pop_warp         pop request from dispatch
//   pop_inst          head entry of pop_warp (combinational mux)
//   flush_valid/flush_warp     discard every entry of one warp
module gelato_ibuffer #(
    parameter int unsigned NUM_WARPS = 4,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned INST_W    = 64,
    parameter int unsigned WID_W     = $clog2(NUM_WARPS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rdy,
    input  logic                 in_valid,
    input  logic [WID_W-1:0]     in_warp,
    input  logic [INST_W-1:0]    in_inst,
    output logic                 in_ready,
    output logic [NUM_WARPS-1:0] warp_full,
    output logic [NUM_WARPS-1:0] head_valid,
    input  logic                 pop_valid,
    input  logic [WID_W-1:0]     pop_warp,
    output logic [INST_W-1:0]    pop_inst,
    input  logic                 flush_valid,
    input  logic [WID_W-1:0]     flush_warp
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [INST_W-1:0] mem_q    [NUM_WARPS][DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q [NUM_WARPS];
    logic [PTR_W-1:0]  rd_ptr_d [NUM_WARPS];
    logic [PTR_W-1:0]  wr_ptr_q [NUM_WARPS];
    logic [PTR_W-1:0]  wr_ptr_d [NUM_WARPS];
    logic [CNT_W-1:0]  cnt_q    [NUM_WARPS];
    logic [CNT_W-1:0]  cnt_d    [NUM_WARPS];

    logic push, pop, flush, mem_we;

    // in_ready looks only at the current count: a same-cycle pop does not
    // make room, so a full FIFO is never written through.
    assign in_ready = cnt_q[in_warp] < CNT_W'(DEPTH);
    assign pop_inst = mem_q[pop_warp][rd_ptr_q[pop_warp]];

    always_comb begin
        for (int w = 0; w < NUM_WARPS; w++) begin
            warp_full[w]  = cnt_q[w] == CNT_W'(DEPTH);
            head_valid[w] = cnt_q[w] != '0;
        end
    end

    assign push  = rdy && in_valid && in_ready;
    assign pop   = rdy && pop_valid && head_valid[pop_warp];
    assign flush = rdy && flush_valid;
    // A flush of the target warp swallows the same-cycle push.
    assign mem_we = push && !(flush && (flush_warp == in_warp));

    always_comb begin
        for (int w = 0; w < NUM_WARPS; w++) begin
            logic push_w, pop_w, flush_w;
            flush_w = flush && (flush_warp == WID_W'(w));
            push_w  = push && (in_warp == WID_W'(w)) && !flush_w;
            pop_w   = pop && (pop_warp == WID_W'(w)) && !flush_w;

            rd_ptr_d[w] = rd_ptr_q[w];
            wr_ptr_d[w] = wr_ptr_q[w];
            cnt_d[w]    = cnt_q[w] + CNT_W'(push_w) - CNT_W'(pop_w);

            if (push_w) wr_ptr_d[w] = wr_ptr_q[w] + PTR_W'(1);
            if (pop_w)  rd_ptr_d[w] = rd_ptr_q[w] + PTR_W'(1);
            if (flush_w) begin
                rd_ptr_d[w] = wr_ptr_q[w];
                cnt_d[w]    = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int w = 0; w < NUM_WARPS; w++) begin
            if (rst_n) begin
                rd_ptr_q[w] <= '0;
                wr_ptr_q[w] <= '0;
                cnt_q[w]    <= '0;
            end else begin
                rd_ptr_q[w] <= rd_ptr_d[w];
                wr_ptr_q[w] <= wr_ptr_d[w];
                cnt_q[w]    <= cnt_d[w];
            end
        end
    end

    // Payload storage carries no reset.
    always_ff @(posedge clk) begin
        if (!rst_n && mem_we) begin
            mem_q[in_warp][wr_ptr_q[in_warp]] <= in_inst;
        end
    end

endmodule

// File: tb/tb_gelato_ibuffer.sv
module tb_gelato_ibuffer;

    localparam int NW = 4;
    localparam int D  = 4;
    localparam int IW = 64;
    localparam int WW = 2;

    logic          clk = 1'b0;
    logic          rst_n, rdy, in_valid, pop_valid, flush_valid;
    logic [WW-1:0] in_warp, pop_warp, flush_warp;
    logic [IW-1:0] in_inst, pop_inst;
    logic          in_ready;
    logic [NW-1:0] warp_full, head_valid;

    always #5 clk = ~clk;

    gelato_ibuffer #(
        .NUM_WARPS(NW), .DEPTH(D), .INST_W(IW), .WID_W(WW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy),
        .in_valid(in_valid), .in_warp(in_warp), .in_inst(in_inst),
        .in_ready(in_ready), .warp_full(warp_full), .head_valid(head_valid),
        .pop_valid(pop_valid), .pop_warp(pop_warp), .pop_inst(pop_inst),
        .flush_valid(flush_valid), .flush_warp(flush_warp)
    );

    // Reference model: one plain queue per warp.
    logic [IW-1:0] mq [NW][$];
    bit            mvalid = 0;
    int            n_vec  = 0;
    int            n_fail = 0;

    task automatic check(input string tag, input logic [IW-1:0] obs, input logic [IW-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle, compare pre-edge outputs with the model, then advance.
    task automatic cyc(input bit r, input bit rd, input bit iv, input int iw,
                       input logic [IW-1:0] ii, input bit pv, input int pw,
                       input bit fv, input int fw);
        logic [NW-1:0] ef, eh;
        bit push_ok, pop_ok;
        rst_n = r; rdy = rd; in_valid = iv; in_warp = WW'(iw); in_inst = ii;
        pop_valid = pv; pop_warp = WW'(pw); flush_valid = fv; flush_warp = WW'(fw);
        #1;
        if (mvalid) begin
            for (int w = 0; w < NW; w++) begin
                ef[w] = mq[w].size() == D;
                eh[w] = mq[w].size() != 0;
            end
            check("in_ready", {63'd0, in_ready}, {63'd0, mq[iw].size() < D});
            check("warp_full", {60'd0, warp_full}, {60'd0, ef});
            check("head_valid", {60'd0, head_valid}, {60'd0, eh});
            if (mq[pw].size() != 0) check("pop_inst", pop_inst, mq[pw][0]);
        end
        push_ok = iv && (mq[iw].size() < D);
        pop_ok  = pv && (mq[pw].size() != 0);
        @(posedge clk);
        if (r) begin
            for (int w = 0; w < NW; w++) mq[w].delete();
            mvalid = 1;
        end else if (rd) begin
            if (pop_ok && !(fv && fw == pw)) void'(mq[pw].pop_front());
            if (push_ok && !(fv && fw == iw)) mq[iw].push_back(ii);
            if (fv) mq[fw].delete();
        end
        #1;
    endtask

    task automatic idle();
        cyc(0, 1, 0, 0, '0, 0, 0, 0, 0);
    endtask

    task automatic push(input int w, input logic [IW-1:0] d);
        cyc(0, 1, 1, w, d, 0, 0, 0, 0);
    endtask

    task automatic popw(input int w);
        cyc(0, 1, 0, 0, '0, 1, w, 0, 0);
    endtask

    initial begin
        cyc(1, 0, 0, 0, '0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, '0, 0, 0, 0, 0);
        for (int w = 0; w < NW; w++) begin
            in_warp = WW'(w); #1;
            check("reset_in_ready", {63'd0, in_ready}, 64'd1);
        end

        // Fill warp 1, then drain it.
        for (int i = 0; i < 4; i++) push(1, 64'hA0 + 64'(i));
        check("w1_full", {60'd0, warp_full}, 64'b0010);
        in_warp = 2'd1; #1;
        check("w1_in_ready", {63'd0, in_ready}, 64'd0);
        push(1, 64'hBAD);
        for (int i = 0; i < 4; i++) begin
            pop_warp = 2'd1; #1;
            check("w1_order", pop_inst, 64'hA0 + 64'(i));
            popw(1);
        end
        check("w1_empty", {63'd0, head_valid[1]}, 64'd0);

        // Interleaved pushes to warps 0/2/3 with rotating pops.
        for (int i = 0; i < 16; i++) begin
            int tw;
            tw = (i % 3 == 0) ? 0 : (i % 3 == 1) ? 2 : 3;
            cyc(0, 1, 1, tw, {32'(tw), 32'(i)}, 1, i % 4, 0, 0);
        end
        for (int i = 0; i < 8; i++) popw(i % 4);

        // Full warp 0: dropped push alongside a pop frees exactly one slot.
        cyc(1, 1, 0, 0, '0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) push(0, 64'hC0 + 64'(i));
        cyc(0, 1, 1, 0, 64'hDEAD, 1, 0, 0, 0);
        in_warp = 2'd0; #1;
        check("w0_ready_after_pop", {63'd0, in_ready}, 64'd1);
        check("w0_not_full", {63'd0, warp_full[0]}, 64'd0);
        for (int i = 1; i < 4; i++) begin
            pop_warp = 2'd0; #1;
            check("w0_remaining", pop_inst, 64'hC0 + 64'(i));
            popw(0);
        end
        check("w0_count3_empty", {63'd0, head_valid[0]}, 64'd0);

        // Flush warp 2 with a same-cycle push that must be dropped.
        push(2, 64'h11);
        push(2, 64'h22);
        cyc(0, 1, 1, 2, 64'h55, 0, 0, 1, 2);
        check("w2_flushed", {63'd0, head_valid[2]}, 64'd0);
        push(2, 64'h66);
        pop_warp = 2'd2; #1;
        check("w2_after_flush", pop_inst, 64'h66);
        popw(2);

        // Wrap-around through warp 3 with occupancy toggling 1/2.
        push(3, 64'h300);
        for (int i = 1; i < 10; i++) begin
            push(3, 64'h300 + 64'(i));
            popw(3);
        end
        popw(3);
        check("w3_drained", {63'd0, head_valid[3]}, 64'd0);

        // Frozen by rdy = 0, then reset while rdy = 0.
        push(1, 64'h77);
        push(0, 64'h78);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 1, 64'h99, 1, 1, 1, 0);
        check("frozen_head", {60'd0, head_valid}, 64'b0011);
        pop_warp = 2'd1; #1;
        check("frozen_data", pop_inst, 64'h77);
        cyc(1, 0, 1, 1, 64'h99, 1, 1, 0, 0);
        check("reset_rdy0_head", {60'd0, head_valid}, 64'd0);
        check("reset_rdy0_full", {60'd0, warp_full}, 64'd0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 99) < 2, $urandom_range(0, 9) != 0,
                $urandom_range(0, 3) != 0, $urandom_range(0, NW - 1),
                {$urandom, $urandom}, $urandom_range(0, 2) != 0,
                $urandom_range(0, NW - 1), $urandom_range(0, 19) == 0,
                $urandom_range(0, NW - 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
